// File: rtl/alu_issue_stage_if.sv
// Instruction, ALU-issue and writeback signals of the ALU issue stage.
// The slave view belongs to the stage; the master view drives it.
interface alu_issue_stage_if;
  // Upstream instruction handshake
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;

  // Issued operation toward the ALU
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [2:0]  func;
  logic [6:0]  auxFunc;
  logic [4:0]  ex_rd;

  // Register-file writeback
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        illegal_inst;

  modport slave (
    input  inst_valid, inst, ex_ready, wb_en, wb_rd, wb_data,
    output inst_ready, ex_valid, opA, opB, func, auxFunc, ex_rd, illegal_inst
  );

  modport master (
    output inst_valid, inst, ex_ready, wb_en, wb_rd, wb_data,
    input  inst_ready, ex_valid, opA, opB, func, auxFunc, ex_rd, illegal_inst
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the RV32I single-cycle ALU.
// Holds the register file and a per-register pending scoreboard.
module alu_issue_stage (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011
  } opcode_e;

  logic [31:0] rf_q [32];
  logic [31:0] pend_q, pend_d;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  func_q, func_d;
  logic [6:0]  aux_q, aux_d;
  logic [4:0]  rd_q, rd_d;
  logic        ill_q, ill_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_sext;
  logic        is_r, is_i, legal, is_shift_imm;
  logic        wb_live;
  logic [31:0] clr_mask, pend_live;
  logic        hazard, out_free, ready, accept, issue;
  logic [31:0] rs1_val, rs2_val;

  always_comb begin
    opcode       = bus.inst[6:0];
    rd           = bus.inst[11:7];
    f3           = bus.inst[14:12];
    rs1          = bus.inst[19:15];
    rs2          = bus.inst[24:20];
    f7           = bus.inst[31:25];
    imm_sext     = {{20{bus.inst[31]}}, bus.inst[31:20]};
    is_r         = (opcode == OPC_OP);
    is_i         = (opcode == OPC_OP_IMM);
    legal        = is_r || is_i;
    is_shift_imm = (f3 == 3'b001) || (f3 == 3'b101);
  end

  // Hazards are judged against the scoreboard as it stands after this
  // cycle's writeback, so a consumer can issue in the writeback cycle.
  always_comb begin
    wb_live  = bus.wb_en && (bus.wb_rd != '0);
    clr_mask = '0;
    if (wb_live) clr_mask[bus.wb_rd] = 1'b1;
    pend_live = pend_q & ~clr_mask;
    hazard    = pend_live[rs1] || (is_r && pend_live[rs2]) || pend_live[rd];
  end

  always_comb begin
    rs1_val = rf_q[rs1];
    if (rs1 == '0) rs1_val = '0;
    else if (wb_live && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;

    rs2_val = rf_q[rs2];
    if (rs2 == '0) rs2_val = '0;
    else if (wb_live && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
  end

  always_comb begin
    out_free = !ex_valid_q || bus.ex_ready;
    ready    = out_free && !(legal && hazard);
    accept   = bus.inst_valid && ready;
    issue    = accept && legal;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    func_d     = func_q;
    aux_d      = aux_q;
    rd_d       = rd_q;
    ill_d      = accept && !legal;
    pend_d     = pend_live;

    if (issue) begin
      ex_valid_d = 1'b1;
      opa_d      = rs1_val;
      opb_d      = is_r ? rs2_val : imm_sext;
      func_d     = f3;
      aux_d      = (is_r || is_shift_imm) ? f7 : '0;
      rd_d       = rd;
      pend_d[rd] = 1'b1;
    end else if (out_free) begin
      ex_valid_d = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      func_q     <= '0;
      aux_q      <= '0;
      rd_q       <= '0;
      ill_q      <= 1'b0;
      pend_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      func_q     <= func_d;
      aux_q      <= aux_d;
      rd_q       <= rd_d;
      ill_q      <= ill_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_live) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.inst_ready   = ready;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.opA          = opa_q;
  assign bus.opB          = opb_q;
  assign bus.func         = func_q;
  assign bus.auxFunc      = aux_q;
  assign bus.ex_rd        = rd_q;
  assign bus.illegal_inst = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: an architectural model checked every
// cycle, plus literal expectations at the interesting points.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage_if b ();
  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(b));

  int checks = 0;
  int errors = 0;

  // ---------------- architectural model ----------------
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  bit          m_exv, m_ill;
  logic [31:0] m_opa, m_opb;
  logic [2:0]  m_func;
  logic [6:0]  m_aux;
  logic [4:0]  m_rd;
  bit          started = 0;

  function automatic bit busy_now(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !(b.wb_en && b.wb_rd == r);
  endfunction

  function automatic logic [31:0] reg_now(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (b.wb_en && b.wb_rd == r) return b.wb_data;
    return m_rf[r];
  endfunction

  function automatic bit model_ready();
    logic [31:0] w;
    bit is_r, legal, haz;
    w     = b.inst;
    is_r  = (w[6:0] == 7'h33);
    legal = is_r || (w[6:0] == 7'h13);
    haz   = busy_now(w[19:15]) || (is_r && busy_now(w[24:20])) || busy_now(w[11:7]);
    return (!m_exv || b.ex_ready) && !(legal && haz);
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    bit rdy, acc, is_r, is_i;
    started = 1;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
      m_exv = 0; m_ill = 0; m_opa = 0; m_opb = 0; m_func = 0; m_aux = 0; m_rd = 0;
    end else begin
      w    = b.inst;
      rdy  = model_ready();
      acc  = b.inst_valid && rdy;
      is_r = (w[6:0] == 7'h33);
      is_i = (w[6:0] == 7'h13);
      if (acc && (is_r || is_i)) begin
        m_opa  = reg_now(w[19:15]);
        m_opb  = is_r ? reg_now(w[24:20]) : {{20{w[31]}}, w[31:20]};
        m_func = w[14:12];
        m_aux  = (is_r || w[14:12] == 3'd1 || w[14:12] == 3'd5) ? w[31:25] : 7'd0;
        m_rd   = w[11:7];
        m_exv  = 1;
      end else if (!m_exv || b.ex_ready) begin
        m_exv = 0;
      end
      m_ill = acc && !(is_r || is_i);
      if (b.wb_en && b.wb_rd != 0) begin
        m_busy[b.wb_rd] = 0;
        m_rf[b.wb_rd]   = b.wb_data;
      end
      if (acc && (is_r || is_i) && w[11:7] != 0) m_busy[w[11:7]] = 1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("m_inst_ready", 32'(b.inst_ready), 32'(model_ready()));
      cmp("m_ex_valid", 32'(b.ex_valid), 32'(m_exv));
      cmp("m_illegal", 32'(b.illegal_inst), 32'(m_ill));
      cmp("m_opA", b.opA, m_opa);
      cmp("m_opB", b.opB, m_opb);
      cmp("m_func", 32'(b.func), 32'(m_func));
      cmp("m_auxFunc", 32'(b.auxFunc), 32'(m_aux));
      cmp("m_ex_rd", 32'(b.ex_rd), 32'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic setin(input bit v, input logic [31:0] ins, input bit exr,
                       input bit wbe, input logic [4:0] wbr, input logic [31:0] wbd);
    b.inst_valid = v;
    b.inst       = ins;
    b.ex_ready   = exr;
    b.wb_en      = wbe;
    b.wb_rd      = wbr;
    b.wb_data    = wbd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_ex(input string tag, input logic [31:0] a, input logic [31:0] bo,
                        input logic [2:0] f, input logic [6:0] ax, input logic [4:0] r);
    cmp({tag, "_valid"}, 32'(b.ex_valid), 32'd1);
    cmp({tag, "_opA"}, b.opA, a);
    cmp({tag, "_opB"}, b.opB, bo);
    cmp({tag, "_func"}, 32'(b.func), 32'(f));
    cmp({tag, "_aux"}, 32'(b.auxFunc), 32'(ax));
    cmp({tag, "_rd"}, 32'(b.ex_rd), 32'(r));
  endtask

  initial begin
    setin(0, 32'd0, 1, 0, 5'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    tick();
    cmp("rst_ex_valid", 32'(b.ex_valid), 32'd0);
    cmp("rst_opA", b.opA, 32'd0);
    cmp("rst_opB", b.opB, 32'd0);
    cmp("rst_func", 32'(b.func), 32'd0);
    cmp("rst_aux", 32'(b.auxFunc), 32'd0);
    cmp("rst_rd", 32'(b.ex_rd), 32'd0);
    cmp("rst_illegal", 32'(b.illegal_inst), 32'd0);
    rst_n = 1'b1;

    // ADDI x1,x0,-5
    setin(1, 32'hFFB00093, 1, 0, 5'd0, 32'd0);
    #1 cmp("rst_ready", 32'(b.inst_ready), 32'd1);
    tick();
    lit_ex("addi", 32'd0, 32'hFFFFFFFB, 3'd0, 7'd0, 5'd1);

    // x1 pending: consumer blocked, then issues with writeback bypass
    setin(1, enc_r(7'd0, 5'd0, 5'd1, 3'd0, 5'd13), 1, 0, 5'd0, 32'd0);
    #1 cmp("pend1_ready", 32'(b.inst_ready), 32'd0);
    setin(1, enc_r(7'd0, 5'd0, 5'd1, 3'd0, 5'd13), 1, 1, 5'd1, 32'h100);
    #1 cmp("wb1_ready", 32'(b.inst_ready), 32'd1);
    tick();
    lit_ex("byp1", 32'h100, 32'd0, 3'd0, 7'd0, 5'd13);

    setin(0, 32'd0, 1, 1, 5'd5, 32'h80000010); tick();
    setin(0, 32'd0, 1, 1, 5'd6, 32'h12345678); tick();
    setin(0, 32'd0, 1, 1, 5'd7, 32'd3);        tick();

    // Back-pressure: ADD x8,x6,x7 then SUB x9,x6,x7
    setin(1, enc_r(7'd0, 5'd7, 5'd6, 3'd0, 5'd8), 0, 0, 5'd0, 32'd0);
    tick();
    lit_ex("bp_add", 32'h12345678, 32'd3, 3'd0, 7'd0, 5'd8);
    setin(1, enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd9), 0, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 cmp("bp_ready", 32'(b.inst_ready), 32'd0);
      tick();
      lit_ex("bp_hold", 32'h12345678, 32'd3, 3'd0, 7'd0, 5'd8);
    end
    setin(1, enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd9), 1, 0, 5'd0, 32'd0);
    #1 cmp("bp_rel_ready", 32'(b.inst_ready), 32'd1);
    tick();
    lit_ex("bp_sub", 32'h12345678, 32'd3, 3'd0, 7'h20, 5'd9);
    setin(0, 32'd0, 1, 0, 5'd0, 32'd0);
    tick();
    cmp("drain_valid", 32'(b.ex_valid), 32'd0);

    // RAW: ADDI x2,x0,7 ; ADD x3,x2,x2 waits for writeback of x2
    setin(1, enc_i(12'd7, 5'd0, 3'd0, 5'd2), 1, 0, 5'd0, 32'd0);
    tick();
    setin(1, enc_r(7'd0, 5'd2, 5'd2, 3'd0, 5'd3), 1, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 cmp("raw_ready", 32'(b.inst_ready), 32'd0);
      tick();
    end
    setin(1, enc_r(7'd0, 5'd2, 5'd2, 3'd0, 5'd3), 1, 1, 5'd2, 32'd7);
    #1 cmp("raw_wb_ready", 32'(b.inst_ready), 32'd1);
    tick();
    lit_ex("raw_add", 32'd7, 32'd7, 3'd0, 7'd0, 5'd3);

    // SRAI x4,x5,3 and ADDI x10,x6 with funct7 bits set, back to back
    setin(1, enc_i(12'h403, 5'd5, 3'd5, 5'd4), 1, 0, 5'd0, 32'd0);
    tick();
    lit_ex("srai", 32'h80000010, 32'h403, 3'd5, 7'h20, 5'd4);
    setin(1, enc_i(12'h405, 5'd6, 3'd0, 5'd10), 1, 0, 5'd0, 32'd0);
    tick();
    lit_ex("addi_aux", 32'h12345678, 32'h405, 3'd0, 7'd0, 5'd10);

    // Same-cycle writeback of x4 and issue of a new x4 writer
    setin(1, enc_i(12'd1, 5'd0, 3'd0, 5'd4), 1, 1, 5'd4, 32'hAA);
    #1 cmp("waw_ready", 32'(b.inst_ready), 32'd1);
    tick();
    lit_ex("waw", 32'd0, 32'd1, 3'd0, 7'd0, 5'd4);
    setin(1, enc_r(7'd0, 5'd0, 5'd4, 3'd0, 5'd11), 1, 0, 5'd0, 32'd0);
    #1 cmp("waw_still_pending", 32'(b.inst_ready), 32'd0);
    setin(0, 32'd0, 1, 1, 5'd4, 32'h55);
    tick();

    // Illegal opcode (LB)
    setin(1, 32'h00000003, 1, 0, 5'd0, 32'd0);
    #1 cmp("ill_ready", 32'(b.inst_ready), 32'd1);
    tick();
    cmp("ill_pulse", 32'(b.illegal_inst), 32'd1);
    cmp("ill_no_valid", 32'(b.ex_valid), 32'd0);
    setin(0, 32'd0, 1, 0, 5'd0, 32'd0);
    tick();
    cmp("ill_one_cycle", 32'(b.illegal_inst), 32'd0);

    // Writeback to x0 has no effect
    setin(0, 32'd0, 1, 1, 5'd0, 32'hDEADBEEF);
    tick();
    setin(1, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd12), 1, 0, 5'd0, 32'd0);
    tick();
    lit_ex("x0", 32'd0, 32'd0, 3'd0, 7'd0, 5'd12);

    // Reset while a consumer is stalled; writeback during reset is ignored
    setin(1, enc_i(12'd9, 5'd0, 3'd0, 5'd2), 1, 0, 5'd0, 32'd0);
    tick();
    setin(1, enc_r(7'd0, 5'd5, 5'd2, 3'd0, 5'd3), 1, 0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1 cmp("rs_stall_ready", 32'(b.inst_ready), 32'd0);
      tick();
    end
    rst_n = 1'b0;
    setin(0, 32'd0, 1, 1, 5'd5, 32'h777);
    tick();
    cmp("rs_valid", 32'(b.ex_valid), 32'd0);
    rst_n = 1'b1;
    setin(1, enc_r(7'd0, 5'd5, 5'd2, 3'd0, 5'd3), 1, 0, 5'd0, 32'd0);
    #1 cmp("rs_ready", 32'(b.inst_ready), 32'd1);
    tick();
    lit_ex("rs_add", 32'd0, 32'd0, 3'd0, 7'd0, 5'd3);

    setin(0, 32'd0, 1, 0, 5'd0, 32'd0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
